uart_rx_ext: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver in the SDRAM test path.
- Adds configurable data width and stop-bit count.
- Adds a runtime baud divisor, 3-sample majority voting and false-start rejection.
- Adds framing/break detection, plus optional parity checking.
- Sits between the board RX pin and the command parser; drives a single-cycle valid strobe with error qualifiers.

---
 rtl/uart_rx_ext.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with runtime baud divisor,
// 3-sample majority voting, false-start rejection, framing and break
// detection, and optional parity checking (macro UART_RX_PARITY_EN).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   baud_div        - clocks per bit (values below 4 act as 4)
//   par_mode        - 0/3 none, 1 even, 2 odd (parity builds only)
//   rx_din          - serial line, idle high
//   rx_dout         - received data word, held until the next rx_vld
//   rx_vld          - one-cycle strobe per completed frame
//   frame_err       - qualifies rx_vld: a stop bit was sampled low
//   parity_err      - qualifies rx_vld: parity mismatch
//   break_det       - qualifies rx_vld: whole frame sampled low
//   busy            - high whenever the receiver is not idle
module uart_rx_ext #(
  parameter int DATA_W      = 8,
  parameter int STOP_BITS   = 1,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        par_mode,
  input  logic              rx_din,
  output logic [DATA_W-1:0] rx_dout,
  output logic              rx_vld,
  output logic              frame_err,
  output logic              parity_err,
  output logic              break_det,
  output logic              busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;
`endif

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       cnt_q;
  logic [3:0]             bit_q;
  logic [DATA_W-1:0]      sh_q;
  logic                   s_lo_q;
  logic                   s_mid_q;
  logic                   ferr_q;
  logic                   stop0_low_q;

  logic                   rx_s;
  logic                   fall;
  logic [DIV_W-1:0]       mid;
  logic                   at_lo;
  logic                   at_mid;
  logic                   at_hi;
  logic                   at_wrap;
  logic                   maj;
  logic [DIV_W-1:0]       cnt_d;
  logic [DATA_W-1:0]      sh_d;
  logic [DIV_W-1:0]       div_d;
  logic                   last_stop;
  logic                   fe_d;
  logic                   stop0_low_d;
  logic                   brk_d;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = hist_q & ~rx_s;
  assign mid     = div_q >> 1;
  assign at_lo   = (cnt_q == mid - DIV_W'(1));
  assign at_mid  = (cnt_q == mid);
  assign at_hi   = (cnt_q == mid + DIV_W'(1));
  assign at_wrap = (cnt_q == div_q - DIV_W'(1));
  assign cnt_d   = at_wrap ? '0 : cnt_q + DIV_W'(1);

  // The decision at m+1 votes the two stored samples with the live one.
  assign maj = (s_lo_q & s_mid_q) | (s_lo_q & rx_s) | (s_mid_q & rx_s);
  assign sh_d = {maj, sh_q[DATA_W-1:1]};
  assign div_d = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

  assign last_stop   = (bit_q == 4'(STOP_BITS - 1));
  assign fe_d        = ferr_q | ~maj;
  assign stop0_low_d = (bit_q == 4'd0) ? ~maj : stop0_low_q;

`ifdef UART_RX_PARITY_EN
  logic [1:0] pmode_q;
  logic       par_q;
  logic       par_use;
  logic       perr_d;

  assign par_use = (pmode_q == 2'd1) | (pmode_q == 2'd2);
  assign perr_d  = par_use &
                   ((^sh_q ^ par_q) != (pmode_q == 2'd2));
  assign brk_d   = (sh_q == '0) & (~par_use | ~par_q) &
                   stop0_low_d;
`else
  logic unused_par;

  assign unused_par = ^par_mode;
  assign parity_err = 1'b0;
  assign brk_d      = (sh_q == '0) & stop0_low_d;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      hist_q      <= 1'b1;
      div_q       <= DIV_W'(4);
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      s_lo_q      <= 1'b1;
      s_mid_q     <= 1'b1;
      ferr_q      <= 1'b0;
      stop0_low_q <= 1'b0;
      rx_dout     <= '0;
      rx_vld      <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pmode_q     <= '0;
      par_q       <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_din};
      hist_q    <= rx_s;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (at_lo)  s_lo_q  <= rx_s;
      if (at_mid) s_mid_q <= rx_s;

      unique case (state_q)
        IDLE: begin
          if (fall) begin
            div_q   <= div_d;
            cnt_q   <= '0;
            bit_q   <= '0;
            ferr_q  <= 1'b0;
            state_q <= START;
`ifdef UART_RX_PARITY_EN
            pmode_q <= par_mode;
`endif
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (at_hi && maj) begin
            state_q <= IDLE;
          end else if (at_wrap) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (at_hi) sh_q <= sh_d;
          if (at_wrap) begin
            if (bit_q == 4'(DATA_W - 1)) begin
              bit_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= par_use ? PARITY : STOP;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_q <= cnt_d;
          if (at_hi)   par_q   <= maj;
          if (at_wrap) state_q <= STOP;
        end
`endif
        STOP: begin
          cnt_q <= cnt_d;
          if (at_hi && last_stop) begin
            // Frame completes at the last stop-bit decision so that a
            // back-to-back start edge is caught from IDLE.
            rx_dout   <= sh_q;
            rx_vld    <= 1'b1;
            frame_err <= fe_d;
            break_det <= brk_d;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_d;
`endif
            cnt_q   <= '0;
            state_q <= fe_d ? WAIT_HIGH : IDLE;
          end else begin
            if (at_hi) begin
              ferr_q      <= fe_d;
              stop0_low_q <= stop0_low_d;
            end
            if (at_wrap) bit_q <= bit_q + 4'd1;
          end
        end
        WAIT_HIGH: begin
          // Require a full bit time of idle line before rearming.
          if (!rx_s) begin
            cnt_q <= '0;
          end else if (at_wrap) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed scoreboard bench for uart_rx_ext.
// Default parameters, baud_div 16.
module tb_uart_rx_ext;
  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'(DIV);
  logic [1:0]  par_mode = 2'd0;
  logic        rx_din = 1'b1;
  logic [7:0]  rx_dout;
  logic        rx_vld;
  logic        frame_err;
  logic        parity_err;
  logic        break_det;
  logic        busy;

  uart_rx_ext dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .par_mode   (par_mode),
    .rx_din     (rx_din),
    .rx_dout    (rx_dout),
    .rx_vld     (rx_vld),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .break_det  (break_det),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       bk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   vld_cnt = 0;
  int   last_vld = 0;
  int   prev_vld = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rx_vld) begin
      vld_cnt++;
      prev_vld = last_vld;
      last_vld = cyc;
      chk("unexpected_vld", 32'(q.size() == 0), 32'd0);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("rx_dout", 32'(rx_dout), 32'(mon_e.d));
        chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
        chk("parity_err", 32'(parity_err), 32'(mon_e.pe));
        chk("break_det", 32'(break_det), 32'(mon_e.bk));
      end
    end else if (rst_n) begin
      chk("idle_flags", 32'({frame_err, parity_err, break_det}), 32'd0);
    end
  end

  task automatic bit_out(input logic b, input int n);
    rx_din = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stp,
                      input logic push);
    exp_t e;
    e.d  = d;
    e.fe = ~stp;
    e.pe = 1'b0;
    e.bk = (d == 8'h00) && !stp;
    if (push) q.push_back(e);
    bit_out(1'b0, DIV);
    for (int i = 0; i < 8; i++) bit_out(d[i], DIV);
    bit_out(stp, DIV);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_p(input logic [7:0] d, input logic pb,
                        input logic [1:0] mode);
    exp_t e;
    e.d  = d;
    e.fe = 1'b0;
    e.pe = ((^d) ^ pb) != (mode == 2'd2);
    e.bk = 1'b0;
    q.push_back(e);
    bit_out(1'b0, DIV);
    for (int i = 0; i < 8; i++) bit_out(d[i], DIV);
    bit_out(pb, DIV);
    bit_out(1'b1, DIV);
  endtask
`endif

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  int t0;
  int lat;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(rx_dout), 32'd0);
    chk("rst_vld", 32'(rx_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({frame_err, parity_err, break_det}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    t0 = cyc;
    send(8'hA5, 1'b1, 1'b1);
    drain("a5_drain");
    lat = last_vld - t0;
    chk("a5_latency", 32'(lat >= 152 && lat <= 160), 32'd1);
    bit_out(1'b1, DIV);
    chk("a5_idle_busy", 32'(busy), 32'd0);

    base = vld_cnt;
    send(8'h3C, 1'b1, 1'b1);
    send(8'hC3, 1'b1, 1'b1);
    drain("b2b_drain");
    chk("b2b_gap", 32'(last_vld - prev_vld), 32'd160);
    chk("b2b_count", 32'(vld_cnt - base), 32'd2);
    bit_out(1'b1, DIV);

    base = vld_cnt;
    bit_out(1'b0, 4);
    bit_out(1'b1, 2);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    bit_out(1'b1, 10);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    bit_out(1'b1, 2 * DIV);
    chk("glitch_no_vld", 32'(vld_cnt - base), 32'd0);

    base = vld_cnt;
    send(8'h55, 1'b0, 1'b1);
    drain("fe_drain");
    bit_out(1'b0, 30 * DIV);
    chk("fe_wait_busy", 32'(busy), 32'd1);
    chk("fe_no_retrig", 32'(vld_cnt - base), 32'd1);
    bit_out(1'b1, 2 * DIV);
    chk("fe_rearm", 32'(busy), 32'd0);
    send(8'h00, 1'b0, 1'b1);
    bit_out(1'b0, 20 * DIV);
    drain("brk_drain");
    chk("brk_count", 32'(vld_cnt - base), 32'd2);
    chk("brk_wait_busy", 32'(busy), 32'd1);
    bit_out(1'b1, 10);
    chk("brk_short_high", 32'(busy), 32'd1);
    bit_out(1'b1, 2 * DIV);
    chk("brk_rearm", 32'(busy), 32'd0);
    chk("brk_no_more", 32'(vld_cnt - base), 32'd2);
    send(8'h3C, 1'b1, 1'b1);
    drain("recover_drain");
    bit_out(1'b1, DIV);

`ifdef UART_RX_PARITY_EN
    par_mode = 2'd1;
    send_p(8'h07, 1'b0, 2'd1);
    drain("par_bad_drain");
    bit_out(1'b1, DIV);
    send_p(8'h07, 1'b1, 2'd1);
    drain("par_ok_drain");
    bit_out(1'b1, DIV);
    par_mode = 2'd0;
`endif

    base = vld_cnt;
    bit_out(1'b0, DIV);
    for (int i = 0; i < 4; i++) bit_out(1'b1, DIV);
    bit_out(1'b1, 8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(rx_dout), 32'd0);
    chk("mid_rst_vld", 32'(rx_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bit_out(1'b1, 5 * DIV);
    chk("mid_rst_no_vld", 32'(vld_cnt - base), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    send(8'h12, 1'b1, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_count", 32'(vld_cnt - base), 32'd1);
    bit_out(1'b1, 2 * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
